// File: rtl/dcache.sv
// Direct-mapped write-through, no-write-allocate data cache for the riscv MEM stage.
// Define DCACHE_STATS_EN to add the hit_cnt/miss_cnt statistics outputs.
module dcache #(
  parameter int LINES       = 4,
  parameter int MEM_LAT_MAX = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd,
  input  logic         wr,
  input  logic         byte_st,
  input  logic [31:0]  addr,
  input  logic [31:0]  wdata,
  output logic [31:0]  rdata,
  output logic         dhit,
  output logic         mem_req,
  output logic         mem_we,
  output logic         mem_byte,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  input  logic         mem_ack,
  input  logic [127:0] mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt
`endif
);

  localparam int IW = $clog2(LINES);
  localparam int TW = 28 - IW;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_WRITE
  } state_e;

  if (LINES < 2 || MEM_LAT_MAX < 0) begin : g_bad_cfg
  end

  state_e          state_q;
  logic            mem_req_q;
  logic            mem_we_q;
  logic            mem_byte_q;
  logic [LINES-1:0] valid_q;
  logic [TW-1:0]   tag_q  [LINES];
  logic [31:0]     data_q [LINES][4];

  logic [IW-1:0]   idx;
  logic [TW-1:0]   tag;
  logic [1:0]      word;
  logic            hit;
  logic            fill_ack;
  logic            wr_ack;

  assign idx      = addr[4 +: IW];
  assign tag      = addr[31 -: TW];
  assign word     = addr[3:2];
  assign hit      = valid_q[idx] && (tag_q[idx] == tag);
  assign fill_ack = (state_q == S_FILL) && mem_ack;
  assign wr_ack   = (state_q == S_WRITE) && mem_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_byte_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (wr) begin
            state_q    <= S_WRITE;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b1;
            mem_byte_q <= byte_st;
          end else if (rd && !hit) begin
            state_q   <= S_FILL;
            mem_req_q <= 1'b1;
            mem_we_q  <= 1'b0;
          end
        end
        S_FILL: begin
          if (mem_ack) begin
            state_q   <= S_IDLE;
            mem_req_q <= 1'b0;
          end
        end
        S_WRITE: begin
          if (mem_ack) begin
            state_q    <= S_IDLE;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_byte_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          mem_req_q  <= 1'b0;
          mem_we_q   <= 1'b0;
          mem_byte_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (fill_ack) begin
      valid_q[idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk) begin
    if (fill_ack) begin
      tag_q[idx]     <= tag;
      data_q[idx][0] <= mem_rdata[31:0];
      data_q[idx][1] <= mem_rdata[63:32];
      data_q[idx][2] <= mem_rdata[95:64];
      data_q[idx][3] <= mem_rdata[127:96];
    end else if (wr_ack && hit) begin
      if (byte_st) begin
        data_q[idx][word][{addr[1:0], 3'b000} +: 8] <= wdata[7:0];
      end else begin
        data_q[idx][word] <= wdata;
      end
    end
  end

  always_comb begin
    dhit  = 1'b1;
    rdata = '0;
    unique case (state_q)
      S_IDLE: begin
        if (wr) begin
          dhit = 1'b0;
        end else if (rd) begin
          dhit = hit;
          if (hit) begin
            rdata = data_q[idx][word];
          end
        end
      end
      S_FILL:  dhit = 1'b0;
      S_WRITE: dhit = mem_ack;
      default: dhit = 1'b0;
    endcase
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_byte  = mem_byte_q;
  assign mem_addr  = mem_we_q ? addr : {addr[31:4], 4'b0000};
  assign mem_wdata = wdata;

`ifdef DCACHE_STATS_EN
  logic        fill_done_q;
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // The hit that completes a fill belongs to that miss, not to hit_cnt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_done_q <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      fill_done_q <= fill_ack;
      if (state_q == S_IDLE && rd && !wr && hit && !fill_done_q) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (state_q == S_IDLE && rd && !wr && !hit) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache.sv
// Directed self-checking bench for dcache: fills, hits, word/byte stores,
// store-miss no-allocate, index aliasing and asynchronous reset during a fill.
module tb_dcache;

  logic         clk;
  logic         reset;
  logic         rd;
  logic         wr;
  logic         byte_st;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic [31:0]  rdata;
  logic         dhit;
  logic         mem_req;
  logic         mem_we;
  logic         mem_byte;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_ack;
  logic [127:0] mem_rdata;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
`endif

  int checks;
  int passed;

  dcache #(.LINES(4), .MEM_LAT_MAX(0)) dut (
    .clk       (clk),
    .reset     (reset),
    .rd        (rd),
    .wr        (wr),
    .byte_st   (byte_st),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .dhit      (dhit),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_byte  (mem_byte),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one load; acks the ack_at-th FILL cycle with line.
  task automatic load_op(
    input  logic [31:0]  a,
    input  int           ack_at,
    input  logic [127:0] line,
    output int           lows,
    output logic [31:0]  rv,
    output logic [31:0]  ma,
    output logic         mw,
    output logic         tout
  );
    logic done;
    int   fc;
    done = 1'b0;
    fc   = 0;
    lows = 0;
    rv   = '0;
    ma   = '0;
    mw   = 1'b0;
    rd   = 1'b1;
    addr = a;
    for (int c = 0; c < 40 && !done; c++) begin
      #4;
      if (dhit) begin
        rv   = rdata;
        done = 1'b1;
      end else begin
        lows++;
        if (mem_req) begin
          fc++;
          ma = mem_addr;
          mw = mem_we;
          if (fc == ack_at) begin
            mem_ack   = 1'b1;
            mem_rdata = line;
          end
        end
      end
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
    end
    rd   = 1'b0;
    tout = !done;
  endtask

  // Runs one store; acks the ack_at-th WRITE cycle.
  task automatic store_op(
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic        b,
    input  int          ack_at,
    output logic        mw,
    output logic        mb,
    output logic [31:0] ma,
    output logic [31:0] md,
    output logic        pre_dhit,
    output logic        ack_dhit,
    output logic        tout
  );
    logic done;
    int   fc;
    done     = 1'b0;
    fc       = 0;
    mw       = 1'b0;
    mb       = 1'b0;
    ma       = '0;
    md       = '0;
    pre_dhit = 1'b0;
    ack_dhit = 1'b0;
    wr       = 1'b1;
    byte_st  = b;
    addr     = a;
    wdata    = d;
    for (int c = 0; c < 40 && !done; c++) begin
      #4;
      if (mem_req) begin
        fc++;
        mw = mem_we;
        mb = mem_byte;
        ma = mem_addr;
        md = mem_wdata;
        if (fc == ack_at) begin
          mem_ack = 1'b1;
          #1;
          ack_dhit = dhit;
          done     = 1'b1;
        end else if (dhit) begin
          pre_dhit = 1'b1;
        end
      end else if (dhit) begin
        pre_dhit = 1'b1;
      end
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
    end
    wr      = 1'b0;
    byte_st = 1'b0;
    tout    = !done;
  endtask

  task automatic pulse_reset;
    rd    = 1'b0;
    wr    = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset;
    rd      = 1'b0;
    wr      = 1'b0;
    byte_st = 1'b0;
    addr    = '0;
    wdata   = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    reset   = 1'b0;
    #2;
    checks++;
    if ({dhit, mem_req, mem_we, mem_byte} !== 4'b1000) begin
      $display("FAIL reset_ctl got dhit/req/we/byte=%b want 1000",
               {dhit, mem_req, mem_we, mem_byte});
    end else passed++;
    checks++;
    if (rdata !== 32'h0) begin
      $display("FAIL reset_rdata got %h want 0", rdata);
    end else passed++;
    @(posedge clk);
    #1;
    reset = 1'b1;
`ifdef DCACHE_STATS_EN
    checks++;
    if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin
      $display("FAIL reset_cnt got %0d/%0d want 0/0", hit_cnt, miss_cnt);
    end else passed++;
`endif
  endtask

  task automatic test_load_miss_hit;
    int lows;
    logic [31:0] rv, ma;
    logic mw, to;
    load_op(32'h104, 3, {32'd4, 32'd3, 32'd2, 32'd1}, lows, rv, ma, mw, to);
    checks++;
    if (to || lows != 4) begin
      $display("FAIL miss_stall got %0d (timeout=%0b) want 4", lows, to);
    end else passed++;
    checks++;
    if (rv !== 32'd2) begin
      $display("FAIL miss_rdata got %h want 2", rv);
    end else passed++;
    checks++;
    if (ma !== 32'h100 || mw !== 1'b0) begin
      $display("FAIL fill_req got addr=%h we=%b want 100/0", ma, mw);
    end else passed++;
    load_op(32'h104, 1, '0, lows, rv, ma, mw, to);
    checks++;
    if (to || lows != 0 || rv !== 32'd2) begin
      $display("FAIL hit_104 got stall=%0d data=%h want 0/2", lows, rv);
    end else passed++;
    load_op(32'h10C, 1, '0, lows, rv, ma, mw, to);
    checks++;
    if (to || lows != 0 || rv !== 32'd4) begin
      $display("FAIL hit_10c got stall=%0d data=%h want 0/4", lows, rv);
    end else passed++;
  endtask

  task automatic test_store_word;
    logic mw, mb, pre, ackd, to;
    logic [31:0] ma, md, rv;
    int lows;
    store_op(32'h108, 32'hDEADBEEF, 1'b0, 2, mw, mb, ma, md, pre, ackd, to);
    checks++;
    if (to || mw !== 1'b1 || mb !== 1'b0 || ma !== 32'h108) begin
      $display("FAIL st_req got we=%b byte=%b addr=%h want 1/0/108",
               mw, mb, ma);
    end else passed++;
    checks++;
    if (md !== 32'hDEADBEEF) begin
      $display("FAIL st_wdata got %h want deadbeef", md);
    end else passed++;
    checks++;
    if (pre !== 1'b0 || ackd !== 1'b1) begin
      $display("FAIL st_dhit got early=%b ack=%b want 0/1", pre, ackd);
    end else passed++;
    #4;
    checks++;
    if (mem_req !== 1'b0 || dhit !== 1'b1) begin
      $display("FAIL st_idle got req=%b dhit=%b want 0/1", mem_req, dhit);
    end else passed++;
    @(posedge clk);
    #1;
    load_op(32'h108, 1, '0, lows, rv, ma, mw, to);
    checks++;
    if (to || lows != 0 || rv !== 32'hDEADBEEF) begin
      $display("FAIL st_readback got stall=%0d data=%h want 0/deadbeef",
               lows, rv);
    end else passed++;
  endtask

  task automatic test_byte_store;
    logic mw, mb, pre, ackd, to;
    logic [31:0] ma, md, rv;
    int lows;
    store_op(32'h108, 32'h0, 1'b0, 1, mw, mb, ma, md, pre, ackd, to);
    store_op(32'h10B, 32'hFFFFFFAB, 1'b1, 1, mw, mb, ma, md, pre, ackd, to);
    checks++;
    if (to || mb !== 1'b1 || mw !== 1'b1 || ma !== 32'h10B) begin
      $display("FAIL bst_req got byte=%b we=%b addr=%h want 1/1/10b",
               mb, mw, ma);
    end else passed++;
    load_op(32'h108, 1, '0, lows, rv, ma, mw, to);
    checks++;
    if (to || lows != 0 || rv !== 32'hAB000000) begin
      $display("FAIL bst_readback got stall=%0d data=%h want 0/ab000000",
               lows, rv);
    end else passed++;
    load_op(32'h104, 1, '0, lows, rv, ma, mw, to);
    checks++;
    if (to || lows != 0 || rv !== 32'd2) begin
      $display("FAIL bst_neighbor got stall=%0d data=%h want 0/2", lows, rv);
    end else passed++;
  endtask

  task automatic test_store_miss;
    logic mw, mb, pre, ackd, to;
    logic [31:0] ma, md, rv;
    int lows;
    store_op(32'h200, 32'h55, 1'b0, 1, mw, mb, ma, md, pre, ackd, to);
    checks++;
    if (to || mw !== 1'b1 || ma !== 32'h200 || ackd !== 1'b1) begin
      $display("FAIL stm_req got we=%b addr=%h ackdhit=%b want 1/200/1",
               mw, ma, ackd);
    end else passed++;
    load_op(32'h200, 2, {32'h13, 32'h12, 32'h11, 32'h10},
            lows, rv, ma, mw, to);
    checks++;
    if (to || lows != 3 || mw !== 1'b0 || ma !== 32'h200) begin
      $display("FAIL stm_noalloc got stall=%0d we=%b addr=%h want 3/0/200",
               lows, mw, ma);
    end else passed++;
    checks++;
    if (rv !== 32'h10) begin
      $display("FAIL stm_fill got %h want 10", rv);
    end else passed++;
  endtask

  task automatic test_alias;
    int l0, l1, l2;
    logic [31:0] rv, ma;
    logic mw, to0, to1, to2;
    pulse_reset();
    load_op(32'h100, 1, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, l0, rv, ma, mw, to0);
    load_op(32'h140, 1, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, l1, rv, ma, mw, to1);
    checks++;
    if (to1 || rv !== 32'hB0) begin
      $display("FAIL alias_data got %h want b0", rv);
    end else passed++;
    load_op(32'h100, 1, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, l2, rv, ma, mw, to2);
    checks++;
    if (to0 || to2 || l0 != 2 || l1 != 2 || l2 != 2) begin
      $display("FAIL alias_miss got stalls=%0d,%0d,%0d want 2,2,2",
               l0, l1, l2);
    end else passed++;
    checks++;
    if (rv !== 32'hA0) begin
      $display("FAIL alias_refill got %h want a0", rv);
    end else passed++;
`ifdef DCACHE_STATS_EN
    checks++;
    if (miss_cnt !== 32'd3 || hit_cnt !== 32'd0) begin
      $display("FAIL alias_cnt got miss=%0d hit=%0d want 3/0",
               miss_cnt, hit_cnt);
    end else passed++;
`endif
  endtask

  task automatic test_reset_fill;
    int lows;
    logic [31:0] rv, ma;
    logic mw, to;
    rd   = 1'b1;
    addr = 32'h150;
    @(posedge clk);
    #5;
    checks++;
    if (mem_req !== 1'b1) begin
      $display("FAIL rf_req got %b want 1", mem_req);
    end else passed++;
    reset = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || dhit !== 1'b0) begin
      $display("FAIL rf_async got req=%b dhit=%b want 0/0", mem_req, dhit);
    end else passed++;
    @(posedge clk);
    #1;
    reset = 1'b1;
    load_op(32'h150, 1, {32'hC3, 32'hC2, 32'hC1, 32'hC0},
            lows, rv, ma, mw, to);
    checks++;
    if (to || lows != 2 || rv !== 32'hC0 || ma !== 32'h150) begin
      $display("FAIL rf_remiss got stall=%0d data=%h addr=%h want 2/c0/150",
               lows, rv, ma);
    end else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_load_miss_hit();
    test_store_word();
    test_byte_store();
    test_store_miss();
    test_alias();
    test_reset_fill();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
